// File: rtl/sipo_frame_pkg.sv
// sipo_frame_pkg
// Shared types and constants for the SIPO frame controller.
//   state_t     : controller states (IDLE / SHIFT / PARITY)
//   DEFAULT_WIDTH : default number of data bits per frame
//   cntWidth()  : bit-counter width for a given frame width
// Optional feature macro: PARITY_CHECK_EN (PARITY is only entered when defined)
package sipo_frame_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 4;

   // A counter must hold 0..w-1; a 2-bit frame still needs one counter bit.
   function automatic int cntWidth(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if
// Bundles the serial input side and the word-level valid/ready side.
//   ser_in, ser_en : serial bit and its strobe
//   word_out, word_valid, word_ready : word handshake
//   busy, overrun  : status
//   parity_err     : parity flag (only with PARITY_CHECK_EN)
// master = source/consumer side, slave = controller side.
interface sipo_frame_ctrl_if #(
   parameter int WIDTH = 4
);

   logic             ser_in;
   logic             ser_en;
   logic [WIDTH-1:0] word_out;
   logic             word_valid;
   logic             word_ready;
   logic             busy;
   logic             overrun;
`ifdef PARITY_CHECK_EN
   logic             parity_err;
`endif

   modport master (
      output ser_in,
      output ser_en,
      output word_ready,
      input  word_out,
      input  word_valid,
      input  busy,
`ifdef PARITY_CHECK_EN
      input  parity_err,
`endif
      input  overrun
   );

   modport slave (
      input  ser_in,
      input  ser_en,
      input  word_ready,
      output word_out,
      output word_valid,
      output busy,
`ifdef PARITY_CHECK_EN
      output parity_err,
`endif
      output overrun
   );

endinterface

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg
// Parameterised serial-in/parallel-out register, MSB-first framing:
// each enabled cycle shifts ser_in into the LSB.
//   clk, rst  : clock, synchronous active-high clear
//   shift_en  : shift strobe
//   ser_in    : serial data bit
//   par_out   : current register contents
module sipo_shift_reg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             ser_in,
   output logic [WIDTH-1:0] par_out
);

   logic [WIDTH-1:0] shift_q;

   // Older bits migrate toward the MSB so the first bit received ends up on top.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
      end else if (shift_en) begin
         shift_q <= {shift_q[WIDTH-2:0], ser_in};
      end
   end

   assign par_out = shift_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl
// Frames a serial bit stream into WIDTH-bit words: waits for a '1' start
// marker, shifts exactly WIDTH data bits into the SIPO, then hands the word
// to a holding register offered downstream with valid/ready.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sipo_frame_ctrl_if.slave (serial input, word handshake, status)
// Optional feature macro: PARITY_CHECK_EN adds an even-parity bit after the
// data bits and drives bus.parity_err.
module sipo_frame_ctrl
   import sipo_frame_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   sipo_frame_ctrl_if.slave  bus
);

   localparam int CNT_W = cntWidth(WIDTH);

   state_t           state_q;
   logic [CNT_W-1:0] bitCnt_q;
   logic [WIDTH-1:0] wordOut_q;
   logic             wordValid_q;
   logic             overrun_q;
   logic [WIDTH-1:0] sipoOut;
   logic             shiftEn;
   logic             lastBit;
   logic             complete_d;
   logic [WIDTH-1:0] word_d;
`ifdef PARITY_CHECK_EN
   logic             parityErr_q;
   logic             parityErr_d;
`else
   logic             unusedSipoMsb;
`endif

   assign shiftEn = bus.ser_en && (state_q == SHIFT);
   assign lastBit = (bitCnt_q == CNT_W'(WIDTH - 1));

   sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shiftEn),
      .ser_in   (bus.ser_in),
      .par_out  (sipoOut)
   );

   // The completed word must include the bit sampled on the completion edge.
   // Without parity that bit is still entering the SIPO, so it is spliced in
   // here; with parity the SIPO is already full when the parity bit arrives.
   always_comb begin
`ifdef PARITY_CHECK_EN
      complete_d  = bus.ser_en && (state_q == PARITY);
      word_d      = sipoOut;
      parityErr_d = (^sipoOut) ^ bus.ser_in;
`else
      complete_d  = shiftEn && lastBit;
      word_d      = {sipoOut[WIDTH-2:0], bus.ser_in};
`endif
   end

`ifndef PARITY_CHECK_EN
   assign unusedSipoMsb = sipoOut[WIDTH-1];
`endif

   // Frame sequencing plus holding register. A completion that meets an
   // unconsumed word with no ready is dropped and flagged; a completion that
   // coincides with a handshake simply replaces the word and keeps valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bitCnt_q    <= '0;
         wordOut_q   <= '0;
         wordValid_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
         parityErr_q <= 1'b0;
`endif
      end else begin
         if (wordValid_q && bus.word_ready) begin
            wordValid_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            parityErr_q <= 1'b0;
`endif
         end

         if (complete_d) begin
            if (wordValid_q && !bus.word_ready) begin
               overrun_q <= 1'b1;
            end else begin
               wordOut_q   <= word_d;
               wordValid_q <= 1'b1;
`ifdef PARITY_CHECK_EN
               parityErr_q <= parityErr_d;
`endif
            end
         end

         case (state_q)
            IDLE: begin
               if (bus.ser_en && bus.ser_in) begin
                  state_q  <= SHIFT;
                  bitCnt_q <= '0;
               end
            end
            SHIFT: begin
               if (bus.ser_en) begin
                  if (lastBit) begin
                     bitCnt_q <= '0;
`ifdef PARITY_CHECK_EN
                     state_q  <= PARITY;
`else
                     state_q  <= IDLE;
`endif
                  end else begin
                     bitCnt_q <= bitCnt_q + CNT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (bus.ser_en) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.word_out   = wordOut_q;
   assign bus.word_valid = wordValid_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.overrun    = overrun_q;
`ifdef PARITY_CHECK_EN
   assign bus.parity_err = parityErr_q;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl
// Directed bench for sipo_frame_ctrl with WIDTH=4. Drives serial strobes and
// the ready line, compares outputs against hand-computed words.
// Optional feature macro: PARITY_CHECK_EN (adds parity bits and parity checks).
module tb_sipo_frame_ctrl;

   localparam int W = 4;

   logic clk;
   logic rst;
   int   assertCount;
   int   failCount;

   sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

   sipo_frame_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One serial strobe; outputs are then sampled 1 unit after the edge.
   task automatic applyStimulus(input logic bitVal, input logic rdy);
      @(negedge clk);
      bus.ser_en     = 1'b1;
      bus.ser_in     = bitVal;
      bus.word_ready = rdy;
      @(posedge clk);
      #1;
      bus.ser_en     = 1'b0;
      bus.ser_in     = 1'b0;
      bus.word_ready = 1'b0;
   endtask

   // One cycle with no strobe, optionally offering ready.
   task automatic idleCycle(input logic rdy);
      @(negedge clk);
      bus.ser_en     = 1'b0;
      bus.word_ready = rdy;
      @(posedge clk);
      #1;
      bus.word_ready = 1'b0;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Marker, data MSB first, then a correct even-parity bit when enabled;
   // lastRdy is presented on the final strobe of the frame.
   task automatic sendFrame(input logic [W-1:0] data, input logic lastRdy);
      applyStimulus(1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
      for (int i = W - 1; i >= 0; i--) applyStimulus(data[i], 1'b0);
      applyStimulus(^data, lastRdy);
`else
      for (int i = W - 1; i >= 0; i--) applyStimulus(data[i], (i == 0) ? lastRdy : 1'b0);
`endif
   endtask

   initial begin
      assertCount    = 0;
      failCount      = 0;
      rst            = 1'b1;
      bus.ser_en     = 1'b0;
      bus.ser_in     = 1'b0;
      bus.word_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      checkOutput("rst_word",    32'(bus.word_out),   32'h0);
      checkOutput("rst_valid",   32'(bus.word_valid), 32'h0);
      checkOutput("rst_busy",    32'(bus.busy),       32'h0);
      checkOutput("rst_overrun", 32'(bus.overrun),    32'h0);
`ifdef PARITY_CHECK_EN
      checkOutput("rst_perr",    32'(bus.parity_err), 32'h0);
`endif

      // First frame 1011, nobody ready.
      sendFrame(4'b1011, 1'b0);
      checkOutput("f1_word",  32'(bus.word_out),   32'hB);
      checkOutput("f1_valid", 32'(bus.word_valid), 32'h1);
      checkOutput("f1_busy",  32'(bus.busy),       32'h0);

      // Consume it.
      idleCycle(1'b1);
      checkOutput("ack_valid",   32'(bus.word_valid), 32'h0);
      checkOutput("ack_word",    32'(bus.word_out),   32'hB);
      checkOutput("ack_overrun", 32'(bus.overrun),    32'h0);

      // Leave 1011 pending, then overrun it with 0110.
      sendFrame(4'b1011, 1'b0);
      checkOutput("f2_valid", 32'(bus.word_valid), 32'h1);
      sendFrame(4'b0110, 1'b0);
      checkOutput("ovr_word",    32'(bus.word_out),   32'hB);
      checkOutput("ovr_valid",   32'(bus.word_valid), 32'h1);
      checkOutput("ovr_overrun", 32'(bus.overrun),    32'h1);
      idleCycle(1'b1);
      idleCycle(1'b0);
      checkOutput("ovr_sticky", 32'(bus.overrun), 32'h1);

      // Only reset clears overrun.
      pulseReset();
      checkOutput("rst2_overrun", 32'(bus.overrun), 32'h0);

      // Completion coincides with a handshake: new word replaces old.
      sendFrame(4'b1110, 1'b0);
      checkOutput("f4_word", 32'(bus.word_out), 32'hE);
      sendFrame(4'b0101, 1'b1);
      checkOutput("coin_word",    32'(bus.word_out),   32'h5);
      checkOutput("coin_valid",   32'(bus.word_valid), 32'h1);
      checkOutput("coin_overrun", 32'(bus.overrun),    32'h0);

      // Drain, idle zeros, then reset in mid-frame.
      idleCycle(1'b1);
      checkOutput("drain_valid", 32'(bus.word_valid), 32'h0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle0_busy", 32'(bus.busy), 32'h0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("marker_busy", 32'(bus.busy), 32'h1);
      idleCycle(1'b0);
      idleCycle(1'b0);
      checkOutput("hold_busy", 32'(bus.busy), 32'h1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      pulseReset();
      checkOutput("midrst_busy",  32'(bus.busy),       32'h0);
      checkOutput("midrst_valid", 32'(bus.word_valid), 32'h0);

      // Fresh frame after the aborted one, with stray no-strobe gaps inside.
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      idleCycle(1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
      applyStimulus(1'b1, 1'b0);
      checkOutput("f5_busy_pre", 32'(bus.busy), 32'h1);
      applyStimulus(1'b0, 1'b0);
`else
      applyStimulus(1'b1, 1'b0);
`endif
      checkOutput("f5_word",  32'(bus.word_out),   32'h3);
      checkOutput("f5_valid", 32'(bus.word_valid), 32'h1);
      checkOutput("f5_busy",  32'(bus.busy),       32'h0);

`ifdef PARITY_CHECK_EN
      // Bad parity: 1011 has odd weight, parity bit 0.
      idleCycle(1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("par_bad_word", 32'(bus.word_out),   32'hB);
      checkOutput("par_bad_err",  32'(bus.parity_err), 32'h1);
      idleCycle(1'b1);
      checkOutput("par_clr_err",  32'(bus.parity_err), 32'h0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("par_ok_word", 32'(bus.word_out),   32'hB);
      checkOutput("par_ok_err",  32'(bus.parity_err), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
